// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: IF stage of the lab pipeline.
//
// Holds the fetch PC, reads a word-addressed instruction memory
// combinationally and registers the result into the IF/ID slot. The control
// unit can hold the stage with freeze (this is how the two-cycle swap opcode
// 6'b111111 keeps its instruction in IF/ID). EXE branch resolution can
// redirect the PC with branch_taken, which squashes the wrong-path slot.
// The memory has a synchronous load port for benches and the boot loader.
//
// Optional feature (macro IF_PERF_CNT_EN): adds saturating stall/flush
// counters. Without the macro those ports and counters do not exist.
//
// Parameters:
//   MEM_DEPTH  number of 32-bit instruction words (power of two, >= 2)
//   PC_W       PC and address width in bits
//   RESET_PC   word-aligned PC loaded on reset
//
// Ports:
//   clk           rising-edge clock
//   rst           synchronous reset, active-high, highest priority
//   freeze        hold PC and IF/ID
//   branch_taken  redirect PC to branch_addr and squash the fetched slot
//   branch_addr   redirect target (byte address, low two bits dropped)
//   imem_we       instruction memory write enable
//   imem_waddr    instruction memory write byte address
//   imem_wdata    instruction memory write data
//   if_instr      IF/ID instruction (opcode = if_instr[31:26])
//   if_pc         IF/ID PC+4 of the fetched instruction
//   if_valid      IF/ID slot holds a real fetched instruction
//   pc            current fetch PC
//   stall_cnt     (IF_PERF_CNT_EN) cycles held by freeze without a branch
//   flush_cnt     (IF_PERF_CNT_EN) cycles with a taken branch
module instr_fetch_unit #(
  parameter int              MEM_DEPTH = 64,
  parameter int              PC_W      = 32,
  parameter logic [PC_W-1:0] RESET_PC  = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            freeze,
  input  logic            branch_taken,
  input  logic [PC_W-1:0] branch_addr,
  input  logic            imem_we,
  input  logic [PC_W-1:0] imem_waddr,
  input  logic [31:0]     imem_wdata,
  output logic [31:0]     if_instr,
  output logic [PC_W-1:0] if_pc,
  output logic            if_valid,
  output logic [PC_W-1:0] pc
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]     stall_cnt,
  output logic [31:0]     flush_cnt
`endif
);

  localparam int AW = $clog2(MEM_DEPTH);
  // One extra bit so a depth equal to the full word-address space still fits.
  localparam logic [PC_W-2:0] DEPTH_EXT = (PC_W-1)'(MEM_DEPTH);

  logic [31:0]     mem [MEM_DEPTH];

  logic            fetch_ok_p0;
  logic [31:0]     fetch_data_p0;
  logic [PC_W-1:0] pc_seq_p0;
  logic            wr_ok;
  logic            unused_bits;

  // Byte-offset bits of the addresses are intentionally ignored.
  assign unused_bits = ^{branch_addr[1:0], imem_waddr[1:0]};

  // ---- Stage p0: combinational fetch from the current PC ----
  // Compare the full word address so high PC bits cannot alias into memory.
  assign fetch_ok_p0   = {1'b0, pc[PC_W-1:2]} < DEPTH_EXT;
  assign fetch_data_p0 = fetch_ok_p0 ? mem[pc[AW+1:2]] : 32'h0;
  assign pc_seq_p0     = pc + PC_W'(4);   // wraps modulo 2^PC_W

  assign wr_ok = {1'b0, imem_waddr[PC_W-1:2]} < DEPTH_EXT;

  // Memory is never reset and accepts writes during reset and freeze. The
  // fetch path reads the array before this nonblocking update lands, giving
  // read-before-write on a same-word collision.
  always_ff @(posedge clk) begin
    if (imem_we && wr_ok) begin
      mem[imem_waddr[AW+1:2]] <= imem_wdata;
    end
  end

  // ---- Stage p1: IF/ID register and PC update ----
  // Priority: reset, then branch (wins over freeze), then freeze, then fetch.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= RESET_PC;
      if_instr <= 32'h0;
      if_pc    <= '0;
      if_valid <= 1'b0;
    end else if (branch_taken) begin
      pc       <= {branch_addr[PC_W-1:2], 2'b00};
      if_instr <= 32'h0;
      if_pc    <= '0;
      if_valid <= 1'b0;
    end else if (!freeze) begin
      pc       <= pc_seq_p0;
      if_instr <= fetch_data_p0;
      if_pc    <= pc_seq_p0;
      if_valid <= fetch_ok_p0;
    end
  end

`ifdef IF_PERF_CNT_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= 32'h0;
      flush_cnt <= 32'h0;
    end else begin
      if (freeze && !branch_taken) stall_cnt <= sat_inc(stall_cnt);
      if (branch_taken)            flush_cnt <= sat_inc(flush_cnt);
    end
  end
`endif

endmodule
